// File: rtl/tpu_result_streamer.sv
// TPU result return path: reads the FP16 result region byte-wise and
// emits one HEADER/LEN/payload/CHK frame on a valid/ready byte stream.
module tpu_result_streamer #(
  parameter int          NUM_WORDS = 8,
  parameter logic [7:0]  BASE_ADDR = 8'd192,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] LEN_B = 8'(2 * NUM_WORDS);
  localparam logic [7:0] LAST  = 8'(2 * NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_CHK,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] sum;
  logic [7:0] cnt;
  logic       accept;

  assign accept = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rd_en    <= 1'b0;
      rd_addr  <= BASE_ADDR;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= 8'd0;
      cnt      <= 8'd0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_HDR;
              tx_data  <= HEADER;
              tx_valid <= 1'b1;
              cnt      <= 8'd0;
              rd_addr  <= BASE_ADDR;
              sum      <= 8'd0;
              busy     <= 1'b1;
            end
          end
          S_HDR: begin
            if (accept) begin
              state   <= S_LEN;
              tx_data <= LEN_B;
              sum     <= LEN_B;
            end
          end
          S_LEN: begin
            if (accept) begin
              state    <= S_FETCH;
              tx_valid <= 1'b0;
              rd_en    <= 1'b1;
            end
          end
          S_FETCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            state    <= S_SEND;
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
            sum      <= sum + rd_data;
          end
          S_SEND: begin
            if (accept) begin
              rd_addr <= rd_addr + 8'd1;
              cnt     <= cnt + 8'd1;
              if (cnt == LAST) begin
                // two's complement makes LEN+payload+CHK sum to zero
                state   <= S_CHK;
                tx_data <= 8'd0 - sum;
              end else begin
                state    <= S_FETCH;
                tx_valid <= 1'b0;
                rd_en    <= 1'b1;
              end
            end
          end
          S_CHK: begin
            if (accept) begin
              state    <= S_DONE;
              tx_valid <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tpu_result_streamer.sv
// Directed bench for tpu_result_streamer: default frame (A) and an
// address-wrapping 4-word frame (B), each with a byte-wide memory model.
module tb_tpu_result_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_start = 1'b0, b_start = 1'b0;
  logic       a_abort = 1'b0, b_abort = 1'b0;
  logic       a_ready = 1'b0, b_ready = 1'b0;
  logic [7:0] a_rd_data = 8'd0, b_rd_data = 8'd0;
  logic       a_rd_en, b_rd_en;
  logic [7:0] a_rd_addr, b_rd_addr;
  logic [7:0] a_tx_data, b_tx_data;
  logic       a_tx_valid, b_tx_valid;
  logic       a_busy, b_busy;
  logic       a_done, b_done;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  int checks = 0;
  int errors = 0;

  logic [7:0] got [$];
  logic [7:0] addrs [$];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int         ncyc;
  bit         seen;

  always #5 clk = ~clk;

  tpu_result_streamer u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_ready),
    .busy(a_busy), .done(a_done)
  );

  tpu_result_streamer #(
    .NUM_WORDS(4), .BASE_ADDR(8'd250), .HEADER(8'hA5)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_ready),
    .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) b_start = 1'b1;
    else a_start = 1'b1;
    step();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Runs from cycle 1 (first cycle after start is sampled) until done,
  // an abort at cycle ab, or maxc cycles. sp/sp2 re-pulse start.
  task automatic run_frame(input bit which, input bit rnd, input int maxc,
                           input int sp, input int sp2, input int ab,
                           output int nc, output bit sn);
    logic       v, dn, stall, r;
    logic [7:0] d, pd;
    got.delete();
    addrs.delete();
    nc = 0;
    sn = 1'b0;
    stall = 1'b0;
    pd = 8'd0;
    for (int c = 1; c <= maxc; c++) begin
      v  = which ? b_tx_valid : a_tx_valid;
      d  = which ? b_tx_data : a_tx_data;
      dn = which ? b_done : a_done;
      if (stall) begin
        chk("hold_valid", 32'(v), 32'd1);
        chk("hold_data", 32'(d), 32'(pd));
      end
      if (dn) begin
        sn = 1'b1;
        nc = c;
        break;
      end
      if (which ? b_rd_en : a_rd_en)
        addrs.push_back(which ? b_rd_addr : a_rd_addr);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == ab) begin
        r = 1'b0;
        a_abort = 1'b1;
        chk("abort_pre_valid", 32'(v), 32'd1);
        chk("abort_pre_data", 32'(d), 32'h42);
      end
      if (c == sp || c == sp2) begin
        if (which) b_start = 1'b1;
        else a_start = 1'b1;
      end
      if (which) b_ready = r;
      else a_ready = r;
      if (v && r) got.push_back(d);
      stall = v && !r;
      pd = d;
      step();
      a_start = 1'b0;
      b_start = 1'b0;
      if (c == ab) begin
        a_abort = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [$]);
    logic [7:0] s;
    chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    s = 8'd0;
    for (int i = 1; i < got.size(); i++) s = s + got[i];
    chk({tag, "_sum"}, 32'(s), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'hEE;
      mem_b[i] = 8'hEE;
    end
    // words 3C00,4000,4200,4400,4500,4600,4700,4800 at 192, low byte first
    mem_a[192] = 8'h00; mem_a[193] = 8'h3C;
    mem_a[194] = 8'h00; mem_a[195] = 8'h40;
    mem_a[196] = 8'h00; mem_a[197] = 8'h42;
    mem_a[198] = 8'h00; mem_a[199] = 8'h44;
    mem_a[200] = 8'h00; mem_a[201] = 8'h45;
    mem_a[202] = 8'h00; mem_a[203] = 8'h46;
    mem_a[204] = 8'h00; mem_a[205] = 8'h47;
    mem_a[206] = 8'h00; mem_a[207] = 8'h48;
    // words 1234,ABCD,00FF,8001 at 250, wrapping past 255
    mem_b[250] = 8'h34; mem_b[251] = 8'h12;
    mem_b[252] = 8'hCD; mem_b[253] = 8'hAB;
    mem_b[254] = 8'hFF; mem_b[255] = 8'h00;
    mem_b[0]   = 8'h01; mem_b[1]   = 8'h80;

    exp_a = '{8'hA5, 8'h10,
              8'h00, 8'h3C, 8'h00, 8'h40, 8'h00, 8'h42, 8'h00, 8'h44,
              8'h00, 8'h45, 8'h00, 8'h46, 8'h00, 8'h47, 8'h00, 8'h48,
              8'hD4};
    exp_b = '{8'hA5, 8'h08,
              8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'h01, 8'h80,
              8'hBA};

    // reset state
    #12;
    chk("rst_rd_en", 32'(a_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(a_rd_addr), 32'd192);
    chk("rst_tx_data", 32'(a_tx_data), 32'd0);
    chk("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_b_rd_addr", 32'(b_rd_addr), 32'd250);
    step();
    rst_n = 1'b1;
    step();
    step();

    // start and abort together in IDLE: abort wins
    a_start = 1'b1;
    a_abort = 1'b1;
    step();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("sa_busy", 32'(a_busy), 32'd0);
    chk("sa_valid", 32'(a_tx_valid), 32'd0);
    step();
    chk("sa_busy2", 32'(a_busy), 32'd0);

    // 1: basic frame, ready tied high
    pulse_start(1'b0);
    chk("t1_hdr_valid", 32'(a_tx_valid), 32'd1);
    chk("t1_busy", 32'(a_busy), 32'd1);
    run_frame(1'b0, 1'b0, 200, -1, -1, -1, ncyc, seen);
    chk("t1_done_seen", 32'(seen), 32'd1);
    chk("t1_latency", 32'(ncyc), 32'd53);
    chk("t1_busy_after", 32'(a_busy), 32'd0);
    check_frame("t1", exp_a);
    chk("t1_nreads", 32'(addrs.size()), 32'd16);
    if (addrs.size() == 16) begin
      chk("t1_addr_first", 32'(addrs[0]), 32'd192);
      chk("t1_addr_last", 32'(addrs[15]), 32'd207);
    end
    step();
    chk("t1_done_pulse", 32'(a_done), 32'd0);

    // 2: random backpressure
    pulse_start(1'b0);
    run_frame(1'b0, 1'b1, 600, -1, -1, -1, ncyc, seen);
    chk("t2_done_seen", 32'(seen), 32'd1);
    check_frame("t2", exp_a);
    step();

    // 3: abort while payload byte 5 is presented
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 200, -1, -1, 20, ncyc, seen);
    chk("t3_nbytes", 32'(got.size()), 32'd7);
    chk("t3_valid", 32'(a_tx_valid), 32'd0);
    chk("t3_busy", 32'(a_busy), 32'd0);
    chk("t3_rd_en", 32'(a_rd_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_no_done", 32'(a_done), 32'd0);
      step();
    end
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 200, -1, -1, -1, ncyc, seen);
    chk("t3_fresh_done", 32'(seen), 32'd1);
    chk("t3_fresh_latency", 32'(ncyc), 32'd53);
    check_frame("t3_fresh", exp_a);
    step();

    // 4: start re-pulsed mid-payload and in the DONE cycle
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 200, 20, 52, -1, ncyc, seen);
    chk("t4_done_seen", 32'(seen), 32'd1);
    chk("t4_latency", 32'(ncyc), 32'd53);
    check_frame("t4", exp_a);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_idle_valid", 32'(a_tx_valid), 32'd0);
      chk("t4_idle_busy", 32'(a_busy), 32'd0);
    end

    // 5: asynchronous reset mid-payload
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 25, -1, -1, -1, ncyc, seen);
    chk("t5_busy_pre", 32'(a_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rd_en", 32'(a_rd_en), 32'd0);
    chk("t5_rd_addr", 32'(a_rd_addr), 32'd192);
    chk("t5_tx_data", 32'(a_tx_data), 32'd0);
    chk("t5_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("t5_busy", 32'(a_busy), 32'd0);
    chk("t5_done", 32'(a_done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_no_resume", 32'(a_tx_valid), 32'd0);
    pulse_start(1'b0);
    run_frame(1'b0, 1'b0, 200, -1, -1, -1, ncyc, seen);
    chk("t5_done_seen", 32'(seen), 32'd1);
    check_frame("t5", exp_a);
    step();

    // 6: base 250, 4 words, address wrap
    pulse_start(1'b1);
    run_frame(1'b1, 1'b0, 200, -1, -1, -1, ncyc, seen);
    chk("t6_done_seen", 32'(seen), 32'd1);
    chk("t6_latency", 32'(ncyc), 32'd29);
    check_frame("t6", exp_b);
    chk("t6_nreads", 32'(addrs.size()), 32'd8);
    for (int i = 0; i < 8 && i < addrs.size(); i++)
      chk($sformatf("t6_addr%0d", i), 32'(addrs[i]),
          32'((250 + i) % 256));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
